// File: rtl/pc_update_ctrl_if.sv
// Request/response bundle between the main control FSM and the PC sequencer.
// The master side raises requests and the slave side drives the PC/EPC controls.
interface pc_update_ctrl_if;
    logic       inc_req;
    logic       flow_req;
    logic [2:0] flow_kind;
    logic       alu_zero;
    logic       alu_gt;
    logic       exc_req;
    logic [1:0] exc_code;
    logic [2:0] pc_src_sel;
    logic       pc_write;
    logic       epc_write;
    logic       mem_vec_read;
    logic [7:0] vec_addr;
    logic       busy;
    logic       done;
    logic       exc_taken;

    modport master (
        output inc_req, flow_req, flow_kind, alu_zero, alu_gt,
        output exc_req, exc_code,
        input  pc_src_sel, pc_write, epc_write, mem_vec_read,
        input  vec_addr, busy, done, exc_taken
    );

    modport slave (
        input  inc_req, flow_req, flow_kind, alu_zero, alu_gt,
        input  exc_req, exc_code,
        output pc_src_sel, pc_write, epc_write, mem_vec_read,
        output vec_addr, busy, done, exc_taken
    );
endinterface

// File: rtl/pc_update_ctrl.sv
// Sequencer owning every PC update: fetch increment, control flow, exception entry.
// Outputs are registered from the next-state decode, so they track the state entered.
module pc_update_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    pc_update_ctrl_if.slave  bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] INC     = 3'd1;
    localparam logic [2:0] BR_EVAL = 3'd2;
    localparam logic [2:0] FLOW    = 3'd3;
    localparam logic [2:0] EXC_EPC = 3'd4;
    localparam logic [2:0] EXC_RD  = 3'd5;
    localparam logic [2:0] EXC_LD  = 3'd6;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    logic [2:0] state, state_n;
    logic [2:0] kind, kind_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] vec_n;
    logic [2:0] sel_n;
    logic       pw_n, ew_n, rd_n, done_n, exc_n;
    logic       taken;
    logic [7:0] vec_map;

    // Reserved code falls back to the invalid-opcode vector.
    always_comb begin
        case (bus.exc_code)
            2'd1:    vec_map = 8'd254;
            2'd2:    vec_map = 8'd255;
            default: vec_map = 8'd253;
        endcase
    end

    always_comb begin
        case (kind)
            3'd1:    taken = bus.alu_zero;
            3'd2:    taken = !bus.alu_zero;
            3'd3:    taken = bus.alu_zero | !bus.alu_gt;
            3'd4:    taken = bus.alu_gt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        kind_n  = kind;
        cnt_n   = cnt;
        vec_n   = bus.vec_addr;
        sel_n   = 3'b000;
        pw_n    = 1'b0;
        ew_n    = 1'b0;
        rd_n    = 1'b0;
        done_n  = 1'b0;
        exc_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.exc_req) begin
                    state_n = EXC_EPC;
                    ew_n    = 1'b1;
                    vec_n   = vec_map;
                end else if (bus.flow_req) begin
                    kind_n = bus.flow_kind;
                    case (bus.flow_kind)
                        3'd1, 3'd2, 3'd3, 3'd4: state_n = BR_EVAL;
                        3'd5: begin
                            state_n = FLOW;
                            sel_n   = 3'b010;
                            pw_n    = 1'b1;
                            done_n  = 1'b1;
                        end
                        3'd6: begin
                            state_n = FLOW;
                            pw_n    = 1'b1;
                            done_n  = 1'b1;
                        end
                        3'd7: begin
                            state_n = FLOW;
                            sel_n   = 3'b100;
                            pw_n    = 1'b1;
                            done_n  = 1'b1;
                        end
                        default: begin
                            state_n = FLOW;
                            done_n  = 1'b1;
                        end
                    endcase
                end else if (bus.inc_req) begin
                    state_n = INC;
                    pw_n    = 1'b1;
                    done_n  = 1'b1;
                end
            end
            BR_EVAL: begin
                // A late exception wins over the pending branch.
                if (bus.exc_req) begin
                    state_n = EXC_EPC;
                    ew_n    = 1'b1;
                    vec_n   = vec_map;
                end else begin
                    state_n = FLOW;
                    sel_n   = 3'b001;
                    pw_n    = taken;
                    done_n  = 1'b1;
                end
            end
            EXC_EPC: begin
                state_n = EXC_RD;
                rd_n    = 1'b1;
                cnt_n   = WAIT_LOAD;
            end
            EXC_RD: begin
                if (cnt == 4'd0) begin
                    state_n = EXC_LD;
                    sel_n   = 3'b011;
                    pw_n    = 1'b1;
                    done_n  = 1'b1;
                    exc_n   = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                    rd_n  = 1'b1;
                end
            end
            EXC_LD: begin
                state_n = IDLE;
                vec_n   = 8'd0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            kind             <= 3'd0;
            cnt              <= 4'd0;
            bus.pc_src_sel   <= 3'b000;
            bus.pc_write     <= 1'b0;
            bus.epc_write    <= 1'b0;
            bus.mem_vec_read <= 1'b0;
            bus.vec_addr     <= 8'd0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.exc_taken    <= 1'b0;
        end else begin
            state            <= state_n;
            kind             <= kind_n;
            cnt              <= cnt_n;
            bus.pc_src_sel   <= sel_n;
            bus.pc_write     <= pw_n;
            bus.epc_write    <= ew_n;
            bus.mem_vec_read <= rd_n;
            bus.vec_addr     <= vec_n;
            bus.busy         <= (state_n != IDLE);
            bus.done         <= done_n;
            bus.exc_taken    <= exc_n;
        end
    end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs, a negedge
// monitor pops one entry for every cycle the sequencer shows activity.
module tb_pc_update_ctrl;

    typedef struct packed {
        logic [2:0] sel;
        logic       pw;
        logic       ew;
        logic       rd;
        logic [7:0] va;
        logic       done;
        logic       exc;
        logic       busy;
    } obs_t;

    logic clk;
    logic reset;
    pc_update_ctrl_if bus ();

    pc_update_ctrl #(.MEM_WAIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    obs_t sb[$];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [2:0] sel, input logic pw,
                                input logic ew, input logic rd,
                                input logic [7:0] va, input logic done,
                                input logic exc);
        obs_t o;
        o.sel  = sel;
        o.pw   = pw;
        o.ew   = ew;
        o.rd   = rd;
        o.va   = va;
        o.done = done;
        o.exc  = exc;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o.sel  = bus.pc_src_sel;
        o.pw   = bus.pc_write;
        o.ew   = bus.epc_write;
        o.rd   = bus.mem_vec_read;
        o.va   = bus.vec_addr;
        o.done = bus.done;
        o.exc  = bus.exc_taken;
        o.busy = bus.busy;
        return o;
    endfunction

    always @(negedge clk) begin
        obs_t got, exp;
        got = cur();
        if (reset && got != '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%h want=none t=%0t",
                         got, $time);
            end else begin
                exp = sb.pop_front();
                if (got != exp) begin
                    errors++;
                    $display("FAIL seq_output got=%h want=%h t=%0t",
                             got, exp, $time);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.inc_req   = 1'b0;
        bus.flow_req  = 1'b0;
        bus.flow_kind = 3'd0;
        bus.alu_zero  = 1'b0;
        bus.alu_gt    = 1'b0;
        bus.exc_req   = 1'b0;
        bus.exc_code  = 2'd0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s left=%0d want=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic push_exc(input logic [7:0] va);
        sb.push_back(mk(3'b000, 1'b0, 1'b1, 1'b0, va, 1'b0, 1'b0));
        sb.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, va, 1'b0, 1'b0));
        sb.push_back(mk(3'b000, 1'b0, 1'b0, 1'b1, va, 1'b0, 1'b0));
        sb.push_back(mk(3'b011, 1'b1, 1'b0, 1'b0, va, 1'b1, 1'b1));
    endtask

    task automatic do_inc();
        sb.push_back(mk(3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
        @(posedge clk); #1;
        bus.inc_req = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        drain("inc");
    endtask

    task automatic do_branch(input logic [2:0] kind, input logic z,
                             input logic gt, input logic tk);
        sb.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
        sb.push_back(mk(3'b001, tk, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
        @(posedge clk); #1;
        bus.flow_req  = 1'b1;
        bus.flow_kind = kind;
        bus.alu_zero  = z;
        bus.alu_gt    = gt;
        @(posedge clk); #1;
        bus.flow_req = 1'b0;
        @(posedge clk); #1;
        idle_inputs();
        drain("branch");
    endtask

    task automatic do_jump(input logic [2:0] kind, input logic [2:0] sel,
                           input logic pw);
        sb.push_back(mk(sel, pw, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
        @(posedge clk); #1;
        bus.flow_req  = 1'b1;
        bus.flow_kind = kind;
        @(posedge clk); #1;
        idle_inputs();
        drain("jump");
    endtask

    task automatic do_exc(input logic [1:0] code, input logic [7:0] va,
                          input logic all_reqs);
        push_exc(va);
        @(posedge clk); #1;
        bus.exc_req  = 1'b1;
        bus.exc_code = code;
        if (all_reqs) begin
            bus.flow_req  = 1'b1;
            bus.flow_kind = 3'd5;
            bus.inc_req   = 1'b1;
        end
        @(posedge clk); #1;
        idle_inputs();
        drain("exc");
    endtask

    initial begin
        obs_t got;
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        got = cur();
        if (got != '0) begin
            errors++;
            $display("FAIL reset_state got=%h want=0", got);
        end
        reset = 1'b1;

        do_inc();
        do_branch(3'd1, 1'b1, 1'b0, 1'b1);
        do_branch(3'd1, 1'b0, 1'b0, 1'b0);
        do_branch(3'd2, 1'b0, 1'b1, 1'b1);
        do_branch(3'd2, 1'b1, 1'b0, 1'b0);
        do_branch(3'd3, 1'b0, 1'b0, 1'b1);
        do_branch(3'd3, 1'b0, 1'b1, 1'b0);
        do_branch(3'd4, 1'b0, 1'b1, 1'b1);
        do_branch(3'd4, 1'b1, 1'b0, 1'b0);
        do_jump(3'd5, 3'b010, 1'b1);
        do_jump(3'd6, 3'b000, 1'b1);
        do_jump(3'd7, 3'b100, 1'b1);
        do_jump(3'd0, 3'b000, 1'b0);
        do_exc(2'd1, 8'd254, 1'b0);
        do_exc(2'd2, 8'd255, 1'b1);
        do_exc(2'd3, 8'd253, 1'b0);
        do_exc(2'd0, 8'd253, 1'b0);

        // Exception arriving while the branch is being evaluated.
        sb.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
        push_exc(8'd253);
        @(posedge clk); #1;
        bus.flow_req  = 1'b1;
        bus.flow_kind = 3'd1;
        bus.alu_zero  = 1'b1;
        @(posedge clk); #1;
        bus.flow_req = 1'b0;
        bus.exc_req  = 1'b1;
        bus.exc_code = 2'd0;
        @(posedge clk); #1;
        idle_inputs();
        drain("preempt");

        // Requests while busy must not disturb the running exception.
        push_exc(8'd254);
        @(posedge clk); #1;
        bus.exc_req  = 1'b1;
        bus.exc_code = 2'd1;
        @(posedge clk); #1;
        bus.exc_req  = 1'b0;
        bus.inc_req  = 1'b1;
        bus.flow_req = 1'b1;
        bus.flow_kind = 3'd5;
        @(posedge clk); #1;
        bus.exc_req  = 1'b1;
        bus.exc_code = 2'd2;
        @(posedge clk); #1;
        idle_inputs();
        drain("busy_ignore");

        // Asynchronous reset in the middle of the vector read.
        push_exc(8'd255);
        @(posedge clk); #1;
        bus.exc_req  = 1'b1;
        bus.exc_code = 2'd2;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #2;
        checks++;
        if (bus.mem_vec_read !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_rd got=%b want=1", bus.mem_vec_read);
        end
        reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        got = cur();
        if (got != '0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", got);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        do_inc();
        do_branch(3'd1, 1'b1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_queue left=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
